// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two request channels, the ALU-side operand and
// result wires, and the response channel of alu_arbiter.
//   slave  modport - the arbiter's view (takes requests, drives the ALU inputs
//                    and the response)
//   master modport - the environment's view (issuers, ALU instance, consumer)
// Signals:
//   reqN_valid/ready/a/b/op  request channel of requester N (N = 0, 1)
//   alu_a/alu_b/alu_op       registered operands and opcode to the ALU
//   alu_y/alu_zi             ALU result and zero flag
//   rsp_valid/ready/id/y/z   response channel
interface alu_arbiter_if #(
    parameter int width = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [width-1:0] req0_a;
    logic [width-1:0] req0_b;
    logic [3:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [width-1:0] req1_a;
    logic [width-1:0] req1_b;
    logic [3:0]       req1_op;

    logic [width-1:0] alu_a;
    logic [width-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [width-1:0] alu_y;
    logic             alu_zi;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [width-1:0] rsp_y;
    logic             rsp_z;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_y, alu_zi,
        output rsp_valid, rsp_id, rsp_y, rsp_z,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_y, alu_zi,
        input  rsp_valid, rsp_id, rsp_y, rsp_z,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter and sequencer for a shared
// 16-bit combinational ALU that lives outside this block. One operation is in
// flight at a time: IDLE accepts, EXEC waits one cycle for the ALU while its
// inputs are registered, RESP holds the captured result until the consumer
// takes it.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   alu_arbiter_if.slave (request channels, ALU wires, response channel)
//   busy  high whenever the sequencer is not in IDLE
module alu_arbiter #(
    parameter int width = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [width-1:0] alu_a_q, alu_a_d;
    logic [width-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             rsp_id_q, rsp_id_d;
    logic [width-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic grant_s;
    logic ready0_s;
    logic ready1_s;
    logic fire0_s;
    logic fire1_s;

    // Grant: a lone requester wins; under contention prio names the winner.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = prio_q;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Readies are only offered in IDLE and are held low while reset is applied.
    always_comb begin
        ready0_s = (state_q == ST_IDLE) && !rst && (grant_s == 1'b0);
        ready1_s = (state_q == ST_IDLE) && !rst && (grant_s == 1'b1);
        fire0_s  = bus.req0_valid && ready0_s;
        fire1_s  = bus.req1_valid && ready1_s;
    end

    // Next-state and datapath update for the IDLE/EXEC/RESP sequencer.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        rsp_id_d = rsp_id_q;
        rsp_y_d  = rsp_y_q;
        rsp_z_d  = rsp_z_q;

        case (state_q)
            ST_IDLE: begin
                if (fire0_s) begin
                    alu_a_d  = bus.req0_a;
                    alu_b_d  = bus.req0_b;
                    alu_op_d = bus.req0_op;
                    rsp_id_d = 1'b0;
                    state_d  = ST_EXEC;
                end else if (fire1_s) begin
                    alu_a_d  = bus.req1_a;
                    alu_b_d  = bus.req1_b;
                    alu_op_d = bus.req1_op;
                    rsp_id_d = 1'b1;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // ALU inputs have been stable for this whole cycle.
                rsp_y_d = bus.alu_y;
                rsp_z_d = bus.alu_zi;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    // Hand the next contended grant to the other side.
                    prio_d  = ~rsp_id_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with the state they describe.
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            alu_a_q     <= {width{1'b0}};
            alu_b_q     <= {width{1'b0}};
            alu_op_q    <= 4'b0000;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= {width{1'b0}};
            rsp_z_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_z_q     <= rsp_z_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_y      = rsp_y_q;
    assign bus.rsp_z      = rsp_z_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. A behavioural ALU sits
// beside the DUT on the interface; expected results come from computing the
// operation directly on the requester's operands, and expected grants from a
// one-bit "whose turn" variable that flips to the other side after each
// response.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    alu_arbiter_if #(.width(16)) bus ();

    alu_arbiter #(.width(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        prio_m;
    logic [15:0] last_a, last_b;
    logic [3:0]  last_op;

    // Operation semantics of the shared ALU: {zero flag, result}.
    function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
        logic [15:0] y;
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            4'd0:    y = a + b;
            4'd1:    y = a - b;
            4'd2:    y = p[15:0];
            4'd3:    y = a >> b[3:0];
            4'd4:    y = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd5:    y = a ^ b;
            4'd6:    y = a | b;
            4'd7:    y = a & b;
            4'd12:   y = {b[7:0], 8'h00};
            4'd15:   y = a ^ b;
            default: y = 16'h0000;
        endcase
        return {(op == 4'd15) && (a == b), y};
    endfunction

    // The ALU instance that sits next to the arbiter.
    always_comb begin
        {bus.alu_zi, bus.alu_y} = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);
    end

    task automatic set_req(input int side, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] op);
        if (side == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prio_m = 1'b0;
        #1;
    endtask

    // One full transaction from the currently presented requests: waits for
    // the handshake, then follows it through EXEC and RESP (with bp cycles of
    // backpressure). keep=1 leaves the winner's request up as a new operation.
    task automatic serve(input int bp, input bit keep, output int winner);
        int          t;
        int          exp_w;
        logic [15:0] ea, eb, ey;
        logic [3:0]  eop;
        logic        ez;
        t = 0;
        while (!((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
               && t < 8) begin
            @(negedge clk); #1;
            t++;
        end
        n_checks++;
        if (t >= 8) begin
            $display("FAIL accept_timeout: no handshake after %0d cycles, need one", t);
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            winner = -1;
            return;
        end else n_pass++;

        exp_w  = (bus.req0_valid && bus.req1_valid) ? int'(prio_m) : (bus.req1_valid ? 1 : 0);
        winner = (bus.req1_valid && bus.req1_ready) ? 1 : 0;
        n_checks++;
        if (bus.req0_ready && bus.req1_ready)
            $display("FAIL ready_onehot: got both readies high, need at most one");
        else n_pass++;
        n_checks++;
        if (winner != exp_w) $display("FAIL grant: got side %0d, need side %0d", winner, exp_w);
        else n_pass++;

        ea  = (winner == 1) ? bus.req1_a  : bus.req0_a;
        eb  = (winner == 1) ? bus.req1_b  : bus.req0_b;
        eop = (winner == 1) ? bus.req1_op : bus.req0_op;
        {ez, ey} = ref_alu(ea, eb, eop);
        last_a = ea; last_b = eb; last_op = eop;

        @(negedge clk); #1;   // EXEC
        if (!keep) begin
            if (winner == 1) bus.req1_valid = 1'b0;
            else             bus.req0_valid = 1'b0;
        end
        n_checks++;
        if (bus.alu_a !== ea || bus.alu_b !== eb || bus.alu_op !== eop)
            $display("FAIL alu_inputs: got a=%h b=%h op=%h, need a=%h b=%h op=%h",
                     bus.alu_a, bus.alu_b, bus.alu_op, ea, eb, eop);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1 || bus.rsp_valid !== 1'b0 || {bus.req0_ready, bus.req1_ready} !== 2'b00)
            $display("FAIL exec_flags: got busy=%b rsp_valid=%b readies=%b%b, need 1 0 00",
                     busy, bus.rsp_valid, bus.req0_ready, bus.req1_ready);
        else n_pass++;

        @(negedge clk); #1;   // first RESP cycle
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== winner[0] || bus.rsp_y !== ey || bus.rsp_z !== ez)
            $display("FAIL response: got v=%b id=%b y=%h z=%b, need v=1 id=%0d y=%h z=%b",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, winner, ey, ez);
        else n_pass++;

        for (int i = 0; i < bp; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== winner[0] || bus.rsp_y !== ey ||
                bus.rsp_z !== ez || busy !== 1'b1 || {bus.req0_ready, bus.req1_ready} !== 2'b00)
                $display("FAIL backpressure_hold: got v=%b id=%b y=%h z=%b busy=%b rdy=%b%b, need 1 %0d %h %b 1 00",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, busy,
                         bus.req0_ready, bus.req1_ready, winner, ey, ez);
            else n_pass++;
        end

        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        bus.rsp_ready = 1'b0;
        prio_m = (winner == 0) ? 1'b1 : 1'b0;
        n_checks++;
        if (busy !== 1'b0 || bus.rsp_valid !== 1'b0)
            $display("FAIL back_to_idle: got busy=%b rsp_valid=%b, need 0 0", busy, bus.rsp_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        bus.req1_valid = 1'b0;
        set_req(0, 16'h1111, 16'h2222, 4'h0);   // a pending request must not be granted
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
            $display("FAIL reset_ready: got %b%b, need 00", bus.req0_ready, bus.req1_ready);
        else n_pass++;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, busy} !== 20'h0)
            $display("FAIL reset_rsp: got v=%b id=%b y=%h z=%b busy=%b, need all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, busy);
        else n_pass++;
        n_checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 36'h0)
            $display("FAIL reset_alu: got a=%h b=%h op=%h, need 0", bus.alu_a, bus.alu_b, bus.alu_op);
        else n_pass++;
        bus.req0_valid = 1'b0;
        rst = 1'b0;
        prio_m = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_single_add();
        int w;
        set_req(0, 16'h0005, 16'h0003, 4'b0000);
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b1) $display("FAIL add_ready_c0: got %b, need 1", bus.req0_ready);
        else n_pass++;
        serve(0, 1'b0, w);
    endtask

    task automatic test_contention();
        int w;
        apply_reset();
        set_req(0, 16'h0003, 16'h0005, 4'b0001);
        set_req(1, 16'h00FF, 16'h0F0F, 4'b0101);
        #1;
        serve(0, 1'b0, w);
        n_checks++;
        if (w != 0) $display("FAIL contention_first: got id %0d, need 0", w); else n_pass++;
        serve(0, 1'b0, w);
        n_checks++;
        if (w != 1) $display("FAIL contention_second: got id %0d, need 1", w); else n_pass++;
        set_req(0, 16'h0A0A, 16'h0003, 4'b0010);
        set_req(1, 16'h8000, 16'h0001, 4'b0100);
        #1;
        serve(1, 1'b0, w);
        n_checks++;
        if (w != 0) $display("FAIL contention_third: got id %0d, need 0", w); else n_pass++;
        serve(0, 1'b0, w);
    endtask

    task automatic test_beq();
        int w;
        set_req(1, 16'h1234, 16'h1234, 4'b1111);
        #1;
        serve(0, 1'b0, w);
        set_req(1, 16'h1234, 16'h1235, 4'b1111);
        #1;
        serve(2, 1'b0, w);
    endtask

    task automatic test_backpressure();
        int w;
        set_req(0, 16'h00C3, 16'h0004, 4'b0011);
        #1;
        serve(4, 1'b1, w);
        n_checks++;
        if (bus.req0_ready !== 1'b1)
            $display("FAIL next_accept: got req0_ready=%b the cycle after response, need 1", bus.req0_ready);
        else n_pass++;
        bus.req0_a = 16'h0042; bus.req0_b = 16'h0017; bus.req0_op = 4'b1100;
        #1;
        serve(0, 1'b0, w);
    endtask

    task automatic test_reset_mid_op();
        int w;
        set_req(0, 16'h0001, 16'h0001, 4'b0000);
        #1;
        serve(0, 1'b0, w);   // leaves prio pointing at req1
        set_req(0, 16'h7777, 16'h0002, 4'b0010);
        #1;
        @(negedge clk); #1;   // EXEC
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, busy, bus.alu_a, bus.alu_b, bus.alu_op,
             bus.req0_ready, bus.req1_ready} !== 58'h0)
            $display("FAIL mid_reset: got v=%b id=%b y=%h z=%b busy=%b a=%h b=%h op=%h, need all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_z, busy, bus.alu_a, bus.alu_b, bus.alu_op);
        else n_pass++;
        rst = 1'b0;
        prio_m = 1'b0;
        set_req(0, 16'h0010, 16'h0020, 4'b0110);
        set_req(1, 16'h0030, 16'h0040, 4'b0111);
        #1;
        serve(0, 1'b0, w);
        n_checks++;
        if (w != 0) $display("FAIL after_reset_prio: got id %0d, need 0", w); else n_pass++;
        serve(0, 1'b0, w);
    endtask

    task automatic test_idle_withdraw();
        logic [15:0] ey;
        logic        ez;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (bus.alu_a !== last_a || bus.alu_b !== last_b || bus.alu_op !== last_op || busy !== 1'b0)
                $display("FAIL idle_hold: got a=%h b=%h op=%h busy=%b, need a=%h b=%h op=%h busy=0",
                         bus.alu_a, bus.alu_b, bus.alu_op, busy, last_a, last_b, last_op);
            else n_pass++;
        end
        set_req(0, 16'h00AA, 16'h0003, 4'b0011);
        {ez, ey} = ref_alu(16'h00AA, 16'h0003, 4'b0011);
        #1;
        @(negedge clk); #1;   // EXEC: req0 was accepted, req1 pulses now
        bus.req0_valid = 1'b0;
        set_req(1, 16'h5555, 16'h0001, 4'b0000);
        #1;
        n_checks++;
        if (bus.req1_ready !== 1'b0) $display("FAIL pulse_exec: got req1_ready=%b, need 0", bus.req1_ready);
        else n_pass++;
        @(negedge clk); #1;   // RESP
        n_checks++;
        if (bus.req1_ready !== 1'b0 || bus.rsp_id !== 1'b0 || bus.rsp_y !== ey)
            $display("FAIL pulse_resp: got req1_ready=%b id=%b y=%h, need 0 0 %h",
                     bus.req1_ready, bus.rsp_id, bus.rsp_y, ey);
        else n_pass++;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(negedge clk); #1;
        bus.rsp_ready  = 1'b0;
        prio_m = 1'b1;
        last_a = 16'h00AA; last_b = 16'h0003; last_op = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (busy !== 1'b0 || bus.alu_a !== last_a)
                $display("FAIL withdrawn: got busy=%b alu_a=%h, need 0 %h", busy, bus.alu_a, last_a);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int          w;
        int          sel;
        logic [3:0]  ops [12];
        logic [15:0] a, b;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd15, 4'd8, 4'd10};
        for (int r = 0; r < 24; r++) begin
            sel = int'($urandom_range(1, 3));
            for (int s = 0; s < 2; s++) begin
                if (((sel >> s) & 1) == 1 && !(s == 0 ? bus.req0_valid : bus.req1_valid)) begin
                    a = 16'($urandom);
                    b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
                    set_req(s, a, b, ops[$urandom_range(0, 11)]);
                end
            end
            #1;
            serve(int'($urandom_range(0, 3)), 1'b0, w);
        end
        while (bus.req0_valid || bus.req1_valid) begin
            serve(0, 1'b0, w);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = 16'h0; bus.req0_b = 16'h0; bus.req0_op = 4'h0;
        bus.req1_valid = 1'b0; bus.req1_a = 16'h0; bus.req1_b = 16'h0; bus.req1_op = 4'h0;
        bus.rsp_ready  = 1'b0;
        prio_m = 1'b0;
        last_a = 16'h0; last_b = 16'h0; last_op = 4'h0;

        test_reset();
        test_single_add();
        test_contention();
        test_beq();
        test_backpressure();
        test_reset_mid_op();
        test_idle_withdraw();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
